// File: rtl/sl_receiver_if.sv
// sl_receiver_if: configuration and word/status bus of the SL line receiver.
interface sl_receiver_if;
    logic [7:0]  wr_config_w;
    logic        wr_config_en;
    logic [7:0]  r_config_w;
    logic [31:0] data_out;
    logic        rx_valid;
    logic        parity_err;
    logic        length_err;
    logic        frame_err;
    logic        irq;
    logic        rx_ack;
    logic        receive_in_process;
    modport slave(
        input  wr_config_w, wr_config_en, rx_ack,
        output r_config_w, data_out, rx_valid, parity_err, length_err, frame_err, irq, receive_in_process
    );
    modport master(
        output wr_config_w, wr_config_en, rx_ack,
        input  r_config_w, data_out, rx_valid, parity_err, length_err, frame_err, irq, receive_in_process
    );
endinterface

// File: rtl/sl_receiver.sv
// sl_receiver: two-wire SL line receiver with odd parity, word length and framing checks.
// Define SL_RX_GLITCH_FILTER_EN to accept a new line state only after two identical samples.
module sl_receiver #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         SL0,
    input  logic         SL1,
    sl_receiver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BIT, GAP, END} state_t;
    state_t      state_q, state_d;
    logic [1:0]  m_q, s_q, p, p_last_q;
    logic [5:0]  cnt_q, cnt_d, bq_q, bq_d, wbq;
    logic        irqm_q, irqm_d, par_q, par_d;
    logic [31:0] sr_q, sr_d, data_q, data_d, mask;
    logic [9:0]  tmr_q, tmr_d;
    logic [7:0]  cfg_q, cfg_d;
    logic        valid_q, valid_d, perr_q, perr_d, lerr_q, lerr_d, ferr_q, ferr_d, irq_q, irq_d;
    logic        is_bit, same, tout, lok, gd, pe, le, fe;
`ifdef SL_RX_GLITCH_FILTER_EN
    logic [1:0]  t_q, f_q;
    // the held value only moves once the synchroniser has shown the same pair twice
    assign p = (s_q == t_q) ? s_q : f_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= 2'b11;
            f_q <= 2'b11;
        end else begin
            t_q <= s_q;
            f_q <= p;
        end
    end
`else
    assign p = s_q;
`endif
    always_comb begin
        wbq = (bus.wr_config_w[5:0] == 6'd0 || bus.wr_config_w[5:0] > 6'd32) ? 6'd32 : bus.wr_config_w[5:0];
        cfg_d = bus.wr_config_en ? {bus.wr_config_w[7:6], wbq} : cfg_q;
        is_bit = p == 2'b10 || p == 2'b01;
        same = p == p_last_q;
        tout = state_q != IDLE && same && tmr_q == 10'(TIMEOUT_CYCLES - 1);
        tmr_d = (state_q == IDLE || !same) ? 10'd0 : tmr_q + 10'd1;
        lok = cnt_q == bq_q + 6'd1;
        mask = bq_q[5] ? '1 : (32'd1 << bq_q) - 32'd1;
        state_d = state_q;
        cnt_d = cnt_q;
        bq_d = bq_q;
        irqm_d = irqm_q;
        par_d = par_q;
        sr_d = sr_q;
        data_d = data_q;
        gd = 1'b0;
        pe = 1'b0;
        le = 1'b0;
        fe = 1'b0;
        case (state_q)
            IDLE: if (is_bit) begin
                state_d = BIT;
                bq_d = cfg_q[5:0];
                irqm_d = cfg_q[6];
                cnt_d = 6'd1;
                par_d = p[1];
                sr_d[0] = p[1];
            end
            BIT: if (p == 2'b11) state_d = GAP;
                 else if (!same) begin
                     state_d = END;
                     fe = 1'b1;
                 end
            GAP: if (is_bit) begin
                state_d = BIT;
                cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
                par_d = par_q ^ p[1];
                if (cnt_q < bq_q) sr_d[cnt_q[4:0]] = p[1];
            end else if (p == 2'b00) begin
                state_d = END;
                gd = lok && par_q;
                le = !lok;
                pe = !par_q;
                data_d = gd ? sr_q & mask : data_q;
            end
            END: if (p == 2'b11) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tout) begin
            state_d = IDLE;
            fe = 1'b1;
        end
        valid_d = gd;
        perr_d = pe || (perr_q && !bus.rx_ack);
        lerr_d = le || (lerr_q && !bus.rx_ack);
        ferr_d = fe || (ferr_q && !bus.rx_ack);
        irq_d = pe || le || fe || (gd && !irqm_q) || (irq_q && !bus.rx_ack);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= 2'b11;
            s_q <= 2'b11;
            p_last_q <= 2'b11;
            state_q <= IDLE;
            cnt_q <= '0;
            bq_q <= 6'd32;
            irqm_q <= 1'b0;
            par_q <= 1'b0;
            sr_q <= '0;
            data_q <= '0;
            tmr_q <= '0;
            cfg_q <= 8'h20;
            valid_q <= 1'b0;
            perr_q <= 1'b0;
            lerr_q <= 1'b0;
            ferr_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            m_q <= {SL0, SL1};
            s_q <= m_q;
            p_last_q <= p;
            state_q <= state_d;
            cnt_q <= cnt_d;
            bq_q <= bq_d;
            irqm_q <= irqm_d;
            par_q <= par_d;
            sr_q <= sr_d;
            data_q <= data_d;
            tmr_q <= tmr_d;
            cfg_q <= cfg_d;
            valid_q <= valid_d;
            perr_q <= perr_d;
            lerr_q <= lerr_d;
            ferr_q <= ferr_d;
            irq_q <= irq_d;
        end
    end
    assign bus.r_config_w = cfg_q;
    assign bus.data_out = data_q;
    assign bus.rx_valid = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.length_err = lerr_q;
    assign bus.frame_err = ferr_q;
    assign bus.irq = irq_q;
    assign bus.receive_in_process = state_q != IDLE;
endmodule

// File: doc/sl_receiver.md
# sl_receiver

Two-wire SL line receiver, the downstream counterpart of the SL transmitter: it synchronises the SL0/SL1 pair, decodes ONE/ZERO/gap/stop symbols, checks odd parity, word length and framing, and presents each completed word with status to the master. It shares the transmitter's 8-bit configuration format: bits 5:0 are BQ, the number of data bits; bit 6 is IRQM.

## Interface
- TIMEOUT_CYCLES, 64: synchronised clocks without a symbol change inside a word before a frame error (8..1023).
- clk  in  1  system clock, 16 MHz
- rst_n  in  1  asynchronous, active-low reset
- SL0  in  1  line wire 0, asynchronous to clk
- SL1  in  1  line wire 1, asynchronous to clk
- wr_config_w  in  8  configuration write data
- wr_config_en  in  1  configuration write strobe, one cycle
- r_config_w  out  8  current configuration register
- data_out  out  32  last good word, bit 0 = first received bit; unused upper bits 0
- rx_valid  out  1  one-cycle pulse: data_out updated with a good word
- parity_err  out  1  sticky: last word failed odd parity
- length_err  out  1  sticky: received bit count ≠ BQ+1
- frame_err  out  1  sticky: illegal transition or timeout
- irq  out  1  interrupt level, held until rx_ack
- rx_ack  in  1  clears irq and all sticky errors
- receive_in_process  out  1  high from first bit symbol to end of word

## Operation
- SL0/SL1 each pass through a 2-flop synchroniser. The FSM sees the pair p = {s0,s1}.
- Symbol codes: 11 = idle/gap; 10 = ONE; 01 = ZERO; 00 = stop.
- Configuration:
  - Register resets to 8'h20 (BQ=32, IRQM=0). Bit 7 is stored and ignored.
  - A write with BQ=0 or BQ>32 stores BQ=32.
  - BQ and IRQM are copied to shadow copies when a word starts. A write during a word takes effect on the next word.
- FSM states: IDLE, BIT, GAP, END.
  - IDLE: p=10/01 → BIT; shift the bit and set cnt=1. p=00 → ignored.
  - BIT: p=11 → GAP. p unchanged → stay. Opposite bit code or 00 → frame error, go to END.
  - GAP: p=10/01 → BIT; shift the bit and cnt+1. p=00 → END; evaluate the word.
  - END: p=11 → IDLE.
- Bit handling:
  - Bit with index k<BQ is written to data shift register bit k. The bit with index BQ is the parity bit.
  - Bits beyond BQ are discarded.
  - cnt is 6 bits and saturates at 63.
  - A parity accumulator XORs every received bit, including the parity bit.
- Timeout: in BIT, GAP or END, if p is unchanged for TIMEOUT_CYCLES → frame_err and force IDLE.
- Word evaluation on entry to END via 00:
  - Good word: cnt==BQ+1 and accumulator==1. data_out ← shift register with bits ≥BQ zeroed; rx_valid pulses.
  - Otherwise set length_err (cnt≠BQ+1) and/or parity_err (accumulator==0). data_out is unchanged.
- irq:
  - IRQM=0: irq sets on a good word or any error.
  - IRQM=1: irq sets on errors only.
- Same-cycle rx_ack and new event: the set wins over the clear.

## Timing
- Reset values: data_out=0, rx_valid=0, all errors=0, irq=0, receive_in_process=0, r_config_w=8'h20. The FSM is in IDLE and the synchroniser flops reset to 1.
- Latency: 00 applied at the pins in cycle n → rx_valid, data_out and irq valid in cycle n+3.
- Minimum symbol width: 1 clk when the filter is out, 2 clk when it is in.
- receive_in_process:
  - Rises in the cycle the FSM leaves IDLE.
  - Falls on return to IDLE.
- A configuration write appears on r_config_w in the next cycle.
- Reset asserted mid-word aborts the word immediately. No rx_valid is issued.

## Configuration
- SL_RX_GLITCH_FILTER_EN defined: a new p value is accepted only after two consecutive identical synchronised samples.
  - Adds 1 cycle to all latencies.
  - A single-cycle line pulse is ignored.
- SL_RX_GLITCH_FILTER_EN undefined: p is used directly from the synchroniser.

## Test plan
- Reset, BQ=32: send 32'hA5A5_0F01 LSB-first plus correct odd parity bit and stop → rx_valid once, data_out=32'hA5A5_0F01, no errors, irq=1; rx_ack → irq=0.
- Write 8'h08, send 8'h3C with parity bit 1 → data_out=32'h0000_003C. Repeat with parity bit 0 → parity_err=1, data_out unchanged.
- BQ=8, send 6 bits + parity + stop → length_err=1, no rx_valid. Send 10 bits → length_err=1.
- Hold p=10 for TIMEOUT_CYCLES mid-word → frame_err=1, receive_in_process falls, FSM in IDLE. Also drive 10→01 directly → frame_err=1.
- IRQM=1 (write 8'h60): good word → rx_valid=1, irq=0. Parity-bad word → irq=1.
- Write config mid-word with BQ=16 → current 32-bit word still decodes good; next word uses BQ=16. Also assert rst_n low mid-word → all outputs at reset values, no rx_valid.
